// File: rtl/var_mux_n_to_1.sv
// var_mux_n_to_1: snapshots CHANNELS signed WIDTH-bit variables on a single
// `sample` strobe and streams the enabled channels, lowest index first, one
// word per accepted valid/ready beat towards the SPI transmit shifter.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   in_bus       packed inputs, channel k at [k*WIDTH +: WIDTH]
//   ch_enable    channel mask, captured together with the data on `sample`
//   sample       one-cycle request to snapshot inputs and start a frame
//   out_data     current word (MSB inverted when OFFSET_BIN != 0)
//   out_ch       channel index of out_data
//   out_valid    out_data/out_ch valid
//   out_ready    downstream accepts the word on out_valid & out_ready
//   frame_start  high while the first word of a frame is presented
//   frame_end    high while the last word of a frame is presented
//   busy         frame in progress
//   overrun      sticky: `sample` arrived while a frame was still running
//   clr_ovr      clears overrun (a coincident new overrun event wins)
module var_mux_n_to_1 #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned CHANNELS   = 3,
    parameter int unsigned CH_W       = 2,
    parameter int unsigned OFFSET_BIN = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_bus,
    input  logic [CHANNELS-1:0]       ch_enable,
    input  logic                      sample,
    output logic [WIDTH-1:0]          out_data,
    output logic [CH_W-1:0]           out_ch,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      frame_start,
    output logic                      frame_end,
    output logic                      busy,
    output logic                      overrun,
    input  logic                      clr_ovr
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    // XOR pattern converting two's complement to offset binary.
    localparam logic [WIDTH-1:0] FLIP =
        (OFFSET_BIN != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

    logic [0:0]                state_q, state_d;
    logic [CHANNELS*WIDTH-1:0] shadow_q, shadow_d;
    logic [CHANNELS-1:0]       mask_q, mask_d;
    logic [WIDTH-1:0]          out_data_q, out_data_d;
    logic [CH_W-1:0]           out_ch_q, out_ch_d;
    logic                      fs_q, fs_d;
    logic                      fe_q, fe_d;
    logic                      ovr_q, ovr_d;

    // Lowest enabled channel of the incoming mask, taken straight from in_bus
    // because the shadow is loaded at the same edge.
    logic [CH_W-1:0]  first_idx;
    logic [WIDTH-1:0] first_word;
    logic             first_found;
    logic             first_more;

    // Next enabled channel above the one currently presented.
    logic [CH_W-1:0]  nxt_idx;
    logic [WIDTH-1:0] nxt_word;
    logic             nxt_found;
    logic             nxt_more;

    logic accept;
    logic last_accept;
    logic start;

    always_comb begin
        first_idx   = '0;
        first_word  = '0;
        first_found = 1'b0;
        first_more  = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_enable[i]) begin
                if (!first_found) begin
                    first_idx   = CH_W'(i);
                    first_word  = in_bus[i*WIDTH +: WIDTH];
                    first_found = 1'b1;
                end else begin
                    first_more = 1'b1;
                end
            end
        end
    end

    always_comb begin
        nxt_idx   = '0;
        nxt_word  = '0;
        nxt_found = 1'b0;
        nxt_more  = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (mask_q[i] && (i > int'(out_ch_q))) begin
                if (!nxt_found) begin
                    nxt_idx   = CH_W'(i);
                    nxt_word  = shadow_q[i*WIDTH +: WIDTH];
                    nxt_found = 1'b1;
                end else begin
                    nxt_more = 1'b1;
                end
            end
        end
    end

    assign accept      = (state_q == SEND) && out_ready;
    // fe_q marks the word being presented as the frame's last one.
    assign last_accept = accept && fe_q;
    assign start       = sample && first_found && ((state_q == IDLE) || last_accept);

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        mask_d     = mask_q;
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        fs_d       = fs_q;
        fe_d       = fe_q;

        if (start) begin
            state_d    = SEND;
            shadow_d   = in_bus;
            mask_d     = ch_enable;
            out_data_d = first_word ^ FLIP;
            out_ch_d   = first_idx;
            fs_d       = 1'b1;
            fe_d       = !first_more;
        end else if (accept) begin
            if (fe_q || !nxt_found) begin
                state_d = IDLE;
                fs_d    = 1'b0;
                fe_d    = 1'b0;
            end else begin
                out_data_d = nxt_word ^ FLIP;
                out_ch_d   = nxt_idx;
                fs_d       = 1'b0;
                fe_d       = !nxt_more;
            end
        end
    end

    // A sample that coincides with the last-word accept is a legal
    // back-to-back start, not an overrun.
    always_comb begin
        ovr_d = ovr_q;
        if (sample && (state_q == SEND) && !last_accept) begin
            ovr_d = 1'b1;
        end else if (clr_ovr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shadow_q   <= '0;
            mask_q     <= '0;
            out_data_q <= '0;
            out_ch_q   <= '0;
            fs_q       <= 1'b0;
            fe_q       <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            mask_q     <= mask_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
            fs_q       <= fs_d;
            fe_q       <= fe_d;
            ovr_q      <= ovr_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_ch      = out_ch_q;
    assign out_valid   = (state_q == SEND);
    assign busy        = (state_q == SEND);
    assign frame_start = fs_q;
    assign frame_end   = fe_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_var_mux_n_to_1.sv
// Testbench for var_mux_n_to_1: two instances (pass-through and offset
// binary) share one stimulus. A queue model of the expected word stream is
// compared against both on every falling edge; directed literal checks pin
// the model to hand-computed values.
module tb_var_mux_n_to_1;

    logic        clk;
    logic        rst;
    logic [47:0] in_bus;
    logic [2:0]  ch_enable;
    logic        sample;
    logic        out_ready;
    logic        clr_ovr;

    logic [15:0] d0_data, d1_data;
    logic [1:0]  d0_ch, d1_ch;
    logic        d0_valid, d1_valid, d0_fs, d1_fs, d0_fe, d1_fe;
    logic        d0_busy, d1_busy, d0_ovr, d1_ovr;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    var_mux_n_to_1 #(.WIDTH(16), .CHANNELS(3), .CH_W(2), .OFFSET_BIN(0)) dut0 (
        .clk(clk), .rst(rst), .in_bus(in_bus), .ch_enable(ch_enable), .sample(sample),
        .out_data(d0_data), .out_ch(d0_ch), .out_valid(d0_valid), .out_ready(out_ready),
        .frame_start(d0_fs), .frame_end(d0_fe), .busy(d0_busy), .overrun(d0_ovr),
        .clr_ovr(clr_ovr)
    );

    var_mux_n_to_1 #(.WIDTH(16), .CHANNELS(3), .CH_W(2), .OFFSET_BIN(1)) dut1 (
        .clk(clk), .rst(rst), .in_bus(in_bus), .ch_enable(ch_enable), .sample(sample),
        .out_data(d1_data), .out_ch(d1_ch), .out_valid(d1_valid), .out_ready(out_ready),
        .frame_start(d1_fs), .frame_end(d1_fe), .busy(d1_busy), .overrun(d1_ovr),
        .clr_ovr(clr_ovr)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          ch;
        logic [15:0] data;
        bit          fs;
        bit          fe;
    } word_t;

    word_t q[$];
    bit    ovr_m = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Model: the frame is a list of enabled channels in ascending order;
    // one entry leaves the list per cycle with out_ready high.
    always @(posedge clk) begin
        int    was;
        bit    acc, last, st;
        word_t w;
        if (rst) begin
            q.delete();
            ovr_m = 0;
        end else begin
            was  = q.size();
            acc  = (was > 0) && out_ready;
            last = acc && (was == 1);
            if (acc) void'(q.pop_front());
            st = sample && (ch_enable != 3'b000) && ((was == 0) || last);
            if (sample && (was > 0) && !last) ovr_m = 1;
            else if (clr_ovr) ovr_m = 0;
            if (st) begin
                for (int k = 0; k < 3; k++) begin
                    if (ch_enable[k]) begin
                        w.ch   = k;
                        w.data = in_bus[k*16 +: 16];
                        w.fs   = (q.size() == 0);
                        w.fe   = 0;
                        q.push_back(w);
                    end
                end
                q[q.size()-1].fe = 1;
            end
        end
    end

    task automatic cmp_dut(input string tag, input logic [15:0] data, input logic [1:0] ch,
                           input logic valid, input logic fs, input logic fe,
                           input logic busy, input logic ovr, input logic [15:0] flip);
        bit ev;
        ev = (q.size() > 0);
        check({tag, ".valid"}, valid, ev);
        check({tag, ".busy"}, busy, ev);
        check({tag, ".overrun"}, ovr, ovr_m);
        if (ev) begin
            check({tag, ".ch"}, ch, q[0].ch);
            check({tag, ".data"}, data, q[0].data ^ flip);
            check({tag, ".fs"}, fs, q[0].fs);
            check({tag, ".fe"}, fe, q[0].fe);
        end else begin
            check({tag, ".fs_idle"}, fs, 0);
            check({tag, ".fe_idle"}, fe, 0);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_dut("m0", d0_data, d0_ch, d0_valid, d0_fs, d0_fe, d0_busy, d0_ovr, 16'h0000);
            cmp_dut("m1", d1_data, d1_ch, d1_valid, d1_fs, d1_fe, d1_busy, d1_ovr, 16'h8000);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic set_in(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        in_bus = {c, b, a};
    endtask

    // Literal expectation for the word presented in the current cycle.
    task automatic lit(input string name, input logic [15:0] e0, input logic [15:0] e1,
                       input logic [1:0] ech, input logic efs, input logic efe);
        @(negedge clk);
        check({name, ".valid"}, d0_valid, 1);
        check({name, ".data0"}, d0_data, e0);
        check({name, ".data1"}, d1_data, e1);
        check({name, ".ch"}, d0_ch, ech);
        check({name, ".fs"}, d0_fs, efs);
        check({name, ".fe"}, d0_fe, efe);
    endtask

    initial begin
        rst = 1; in_bus = '0; ch_enable = '0; sample = 0; out_ready = 0; clr_ovr = 0;
        step();
        step();
        rst = 0;
        chk_en = 1;
        neg();
        check("reset.data", d0_data, 0);
        check("reset.ch", d0_ch, 0);
        check("reset.valid", d0_valid, 0);
        check("reset.busy", d0_busy, 0);
        check("reset.ovr", d0_ovr, 0);

        // Full mask, continuous ready.
        set_in(16'd100, -16'sd20000, 16'd30000);
        ch_enable = 3'b111; out_ready = 1; sample = 1;
        step(); sample = 0;
        lit("t1w0", 16'h0064, 16'h8064, 2'd0, 1, 0); step();
        lit("t1w1", 16'hB1E0, 16'h31E0, 2'd1, 0, 0); step();
        lit("t1w2", 16'h7530, 16'hF530, 2'd2, 0, 1); step();
        neg(); check("t1end.valid", d0_valid, 0);

        // Mask 101 with ready pattern 0,1,0,0,1.
        ch_enable = 3'b101; out_ready = 0; sample = 1;
        step(); sample = 0;
        lit("t2a", 16'h0064, 16'h8064, 2'd0, 1, 0); step();
        out_ready = 1;
        lit("t2b", 16'h0064, 16'h8064, 2'd0, 1, 0); step();
        out_ready = 0;
        lit("t2c", 16'h7530, 16'hF530, 2'd2, 0, 1); step();
        lit("t2d", 16'h7530, 16'hF530, 2'd2, 0, 1); step();
        out_ready = 1;
        lit("t2e", 16'h7530, 16'hF530, 2'd2, 0, 1); step();
        neg(); check("t2end.valid", d0_valid, 0);

        // Inputs change mid-frame; back-to-back sample on last accept.
        ch_enable = 3'b111; sample = 1;
        step(); sample = 0;
        set_in(16'd1, 16'd2, 16'd3);
        lit("t3w0", 16'h0064, 16'h8064, 2'd0, 1, 0); step();
        lit("t3w1", 16'hB1E0, 16'h31E0, 2'd1, 0, 0); step();
        sample = 1;
        lit("t3w2", 16'h7530, 16'hF530, 2'd2, 0, 1); step();
        sample = 0;
        lit("t3n0", 16'h0001, 16'h8001, 2'd0, 1, 0);
        check("t3.ovr", d0_ovr, 0);
        step();
        lit("t3n1", 16'h0002, 16'h8002, 2'd1, 0, 0); step();
        lit("t3n2", 16'h0003, 16'h8003, 2'd2, 0, 1); step();

        // Overrun while held, clear, and set-wins.
        set_in(16'd100, -16'sd20000, 16'd30000);
        out_ready = 0; sample = 1;
        step(); sample = 0;
        sample = 1;
        step(); sample = 0;
        lit("t4held", 16'h0064, 16'h8064, 2'd0, 1, 0);
        check("t4.ovr_set", d0_ovr, 1);
        clr_ovr = 1;
        step(); clr_ovr = 0;
        neg(); check("t4.ovr_clr", d0_ovr, 0);
        clr_ovr = 1; sample = 1;
        step(); clr_ovr = 0; sample = 0;
        neg(); check("t4.set_wins", d0_ovr, 1);
        check("t4.set_wins1", d1_ovr, 1);
        clr_ovr = 1; out_ready = 1;
        step(); clr_ovr = 0;
        step(); step(); step();
        neg(); check("t4end.valid", d0_valid, 0);

        // Empty mask is ignored.
        ch_enable = 3'b000; sample = 1;
        step(); sample = 0;
        neg();
        check("t5.valid", d0_valid, 0);
        check("t5.busy", d0_busy, 0);
        check("t5.ovr", d0_ovr, 0);
        step();

        // Reset while word 1 is held.
        ch_enable = 3'b111; out_ready = 1; sample = 1;
        step(); sample = 0;
        lit("t6w0", 16'h0064, 16'h8064, 2'd0, 1, 0); step();
        out_ready = 0;
        lit("t6w1", 16'hB1E0, 16'h31E0, 2'd1, 0, 0);
        rst = 1;
        step(); rst = 0;
        neg();
        check("t6.data", d0_data, 0);
        check("t6.data1", d1_data, 0);
        check("t6.ch", d0_ch, 0);
        check("t6.valid", d0_valid, 0);
        check("t6.fs", d0_fs, 0);
        check("t6.fe", d0_fe, 0);
        check("t6.busy", d0_busy, 0);
        check("t6.ovr", d0_ovr, 0);
        out_ready = 1; sample = 1;
        step(); sample = 0;
        lit("t6r0", 16'h0064, 16'h8064, 2'd0, 1, 0); step();
        step(); step();
        neg(); check("t6end.valid", d0_valid, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/var_mux_n_to_1.md
Name: var_mux_n_to_1

Overview:
- Parametrised successor to the fixed 3-channel 16-bit variable multiplexer feeding the SPI transmit path.
- On a `sample` strobe it snapshots N signed W-bit variables at once, so all channels of a frame are coherent.
- It then presents the enabled channels one word at a time over a valid/ready handshake to the SPI shifter, tagged with channel index and frame markers.
- Optional offset-binary conversion, per-frame channel mask, overrun detection.

Parameters:
- WIDTH, 16, bits per channel word (2..32).
- CHANNELS, 3, number of input channels (1..16).
- CH_W, 2, width of channel index; must satisfy 2**CH_W >= CHANNELS.
- OFFSET_BIN, 0, 1 = invert MSB of each output word (two's complement to offset binary), 0 = pass through.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous active-high reset.
- in_bus  in  CHANNELS*WIDTH  packed signed inputs; channel k at bits [k*WIDTH +: WIDTH].
- ch_enable  in  CHANNELS  per-channel enable mask, captured with `sample`.
- sample  in  1  single-cycle request to snapshot inputs and start a frame.
- out_data  out  WIDTH  current word.
- out_ch  out  CH_W  channel index of out_data.
- out_valid  out  1  out_data/out_ch valid.
- out_ready  in  1  downstream accepts the word when out_valid & out_ready.
- frame_start  out  1  high with the first word of a frame.
- frame_end  out  1  high with the last word of a frame.
- busy  out  1  frame in progress.
- overrun  out  1  sticky: `sample` arrived while busy.
- clr_ovr  in  1  clears overrun.

Behaviour:
- Reset (`rst`=1 at a clk edge): state IDLE; out_data=0, out_ch=0, out_valid=0, frame_start=0, frame_end=0, busy=0, overrun=0, shadow registers=0, latched mask=0.
  - Reset mid-frame aborts the frame immediately; no further words are emitted.
- States: IDLE, SEND.
- IDLE, `sample`=1 and ch_enable != 0, at edge E:
  - capture in_bus into shadow registers and ch_enable into the mask;
  - go to SEND; busy=1, out_valid=1;
  - out_ch = lowest enabled index; out_data = that shadow word.
  - Latency: first word is valid in the cycle after `sample`.
- IDLE, `sample`=1 and ch_enable == 0: ignored; no frame, no overrun.
- SEND, word accepted (out_valid & out_ready at an edge):
  - if a higher enabled channel remains, load out_ch/out_data from the next higher enabled channel at that edge; out_valid stays 1;
  - otherwise go to IDLE, out_valid=0, busy=0.
- SEND, out_ready=0: out_data, out_ch, out_valid, frame_start and frame_end hold unchanged (AXI-style; no retraction).
- Frame markers:
  - frame_start=1 only while the first word of the frame is presented;
  - frame_end=1 only while the last enabled word is presented;
  - both are 1 when a single channel is enabled.
- Back-to-back frames:
  - `sample` in the same cycle as acceptance of the last word starts a new frame; no idle cycle and no overrun.
  - The new capture uses that cycle's in_bus.
- `sample` while busy (other than the last-word-accept case): ignored for data; overrun set to 1 at that edge.
- overrun clears on clr_ovr=1. If clr_ovr and a new overrun event occur in the same cycle, set wins.
- OFFSET_BIN=1: out_data = shadow ^ (1<<(WIDTH-1)), applied combinationally on the shadow before the output register. The mask and the shadow are unaffected.
- Shadow registers change only on a frame-start capture; input changes during SEND do not affect emitted words.
- Enabled channels are emitted strictly in ascending index order; disabled channels are skipped with no bubble cycles.
- Throughput: one word per cycle while out_ready=1.

Test Plan:
- WIDTH=16, CHANNELS=3, mask=3'b111, inputs 100/-20000/30000, out_ready=1, one `sample` pulse:
  - out_valid high for exactly 3 consecutive cycles starting 1 cycle after `sample`;
  - out_data 0x0064, 0xB1E0, 0x7530; out_ch 0,1,2;
  - frame_start on word 0, frame_end on word 2.
- Same inputs, mask=3'b101, out_ready toggling 0,1,0,0,1:
  - only ch0 (0x0064) then ch2 (0x7530) emitted;
  - each word held stable while out_ready=0; frame_start on ch0, frame_end on ch2.
- Change in_bus to 1/2/3 during SEND of the first frame:
  - that frame still emits 100/-20000/30000.
  - Second `sample` asserted with acceptance of word 2: next cycle emits 1,2,3; overrun stays 0.
- `sample` pulse in the middle of a frame: overrun=1 and the frame continues unchanged. clr_ovr pulse returns overrun to 0; clr_ovr and `sample`-while-busy together leave overrun=1.
- OFFSET_BIN=1, inputs 100/-20000/30000: out_data 0x8064, 0x31E0, 0xF530. Mask=0 with `sample`: no out_valid, busy stays 0.
- Assert rst while word 1 is held with out_ready=0: next cycle all outputs at reset values; a subsequent `sample` starts a clean frame at ch0 with frame_start=1.
